// File: rtl/cxl_pkg.sv
// ---------------------------------------------------------------------------
// cxl_pkg -- types shared by the get_Cxl requester and responder.
//   client_id_t  : 5-bit requesting client
//   amount_t     : 32-bit requested amount
//   req_state_t  : requester FSM state encoding
//   sat_inc16    : 16-bit saturating increment used by the statistics
//                  counters (present only with CXL_REQ_STATS_EN)
// ---------------------------------------------------------------------------
package cxl_pkg;

  typedef logic [4:0]  client_id_t;
  typedef logic [31:0] amount_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_DONE    = 2'd3
  } req_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cxl_get_requester_if.sv
// ---------------------------------------------------------------------------
// cxl_get_requester_if -- command / request / completion bundle of the
// get_Cxl requester.
//   cmd_*   : upstream command handshake (cmd_valid / cmd_ready)
//   req_*   : request toward the get_Cxl responder, ack returns
//   done_*  : one-cycle completion report
// Modports:
//   master : the requester's view (drives cmd_ready, request and done)
//   slave  : the surrounding logic's view (drives command and ack)
// ---------------------------------------------------------------------------
interface cxl_get_requester_if;
  import cxl_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  client_id_t cmd_client_id;
  amount_t    cmd_amount;

  logic       req_valid;
  client_id_t client_id;
  amount_t    amount;
  logic       ack;

  logic       done_valid;
  logic       done_ok;
  client_id_t done_client_id;

  modport master (
    input  cmd_valid, cmd_client_id, cmd_amount, ack,
    output cmd_ready, req_valid, client_id, amount,
           done_valid, done_ok, done_client_id
  );

  modport slave (
    output cmd_valid, cmd_client_id, cmd_amount, ack,
    input  cmd_ready, req_valid, client_id, amount,
           done_valid, done_ok, done_client_id
  );

endinterface

// File: rtl/cxl_req_timer.sv
// ---------------------------------------------------------------------------
// cxl_req_timer -- per-attempt timeout and attempt counting.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : restart both counters (new command accepted)
//   enable            : an attempt is running with no ack this cycle
//   expired           : the current attempt ends this cycle unanswered
//   retries_exhausted : this expiry is the last allowed attempt
// The timeout counter self-clears on expiry, so the attempt after the
// backoff cycle starts from zero without extra control.
// ---------------------------------------------------------------------------
module cxl_req_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic retries_exhausted
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RTY_LAST = 4'(MAX_RETRY - 1);

  logic [15:0] tmo_q;
  logic [3:0]  rty_q;

  // enable is already gated by ack, so an ack on the last cycle never expires
  assign expired           = enable && (tmo_q == TMO_LAST);
  assign retries_exhausted = expired && (rty_q == RTY_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tmo_q <= '0;
      rty_q <= '0;
    end else if (expired) begin
      tmo_q <= '0;
      rty_q <= rty_q + 4'd1;
    end else if (enable) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

endmodule

// File: rtl/cxl_get_requester.sv
// ---------------------------------------------------------------------------
// cxl_get_requester -- accepts one get command at a time, presents it to the
// get_Cxl responder with timeout/retry, and reports a one-cycle completion.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cxl_get_requester_if.master (command, request, completion)
// Optional build macro CXL_REQ_STATS_EN adds:
//   stat_ok_cnt, stat_fail_cnt, stat_retry_cnt : saturating 16-bit counts of
//   successful dones, failed dones and backoff entries.
// All bus outputs are registered in the FSM. A zero-amount command
// completes successfully without ever presenting a request.
// ---------------------------------------------------------------------------
module cxl_get_requester
  import cxl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  cxl_get_requester_if.master     bus
`ifdef CXL_REQ_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_ok_cnt,
  output logic [STAT_W-1:0]       stat_fail_cnt,
  output logic [STAT_W-1:0]       stat_retry_cnt
`endif
);

  req_state_t state_q;
  logic       cmd_ready_q;
  logic       req_valid_q;
  client_id_t client_id_q;
  amount_t    amount_q;
  logic       done_valid_q;
  logic       done_ok_q;
  client_id_t done_cid_q;

  logic accept, zero_amt, got_ack, expired, exhausted;

  // cmd_ready_q is 0 in the first IDLE cycle after reset, so it gates accept
  assign accept   = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign zero_amt = (bus.cmd_amount == '0);
  assign got_ack  = (state_q == ST_REQ) && bus.ack;

  cxl_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_timer (
    .clk               (clk),
    .rst               (rst),
    .clear             (accept),
    .enable            ((state_q == ST_REQ) && !bus.ack),
    .expired           (expired),
    .retries_exhausted (exhausted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      client_id_q  <= '0;
      amount_q     <= '0;
      done_valid_q <= 1'b0;
      done_ok_q    <= 1'b0;
      done_cid_q   <= '0;
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            client_id_q <= bus.cmd_client_id;
            amount_q    <= bus.cmd_amount;
            if (zero_amt) begin
              state_q      <= ST_DONE;
              done_valid_q <= 1'b1;
              done_ok_q    <= 1'b1;
              done_cid_q   <= bus.cmd_client_id;
            end else begin
              state_q     <= ST_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (got_ack) begin
            state_q      <= ST_DONE;
            req_valid_q  <= 1'b0;
            done_valid_q <= 1'b1;
            done_ok_q    <= 1'b1;
            done_cid_q   <= client_id_q;
          end else if (expired) begin
            req_valid_q <= 1'b0;
            if (exhausted) begin
              state_q      <= ST_DONE;
              done_valid_q <= 1'b1;
              done_ok_q    <= 1'b0;
              done_cid_q   <= client_id_q;
            end else begin
              state_q <= ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          state_q     <= ST_REQ;
          req_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.req_valid      = req_valid_q;
  assign bus.client_id      = client_id_q;
  assign bus.amount         = amount_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_ok        = done_ok_q;
  assign bus.done_client_id = done_cid_q;

`ifdef CXL_REQ_STATS_EN
  logic [STAT_W-1:0] ok_cnt_q, fail_cnt_q, rty_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
      rty_cnt_q  <= '0;
    end else begin
      if ((accept && zero_amt) || got_ack) ok_cnt_q   <= sat_inc16(ok_cnt_q);
      if (exhausted)                       fail_cnt_q <= sat_inc16(fail_cnt_q);
      if (expired && !exhausted)           rty_cnt_q  <= sat_inc16(rty_cnt_q);
    end
  end

  assign stat_ok_cnt    = ok_cnt_q;
  assign stat_fail_cnt  = fail_cnt_q;
  assign stat_retry_cnt = rty_cnt_q;
`endif

endmodule

// File: tb/tb_cxl_get_requester.sv
// ---------------------------------------------------------------------------
// tb_cxl_get_requester -- directed self-checking bench for cxl_get_requester
// (TIMEOUT_CYCLES=16, MAX_RETRY=3). Statistics checks are compiled only when
// CXL_REQ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cxl_get_requester;
  import cxl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cxl_get_requester_if bus_if();

`ifdef CXL_REQ_STATS_EN
  logic [15:0] stat_ok_cnt, stat_fail_cnt, stat_retry_cnt;
`endif

  cxl_get_requester #(
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef CXL_REQ_STATS_EN
    ,
    .stat_ok_cnt    (stat_ok_cnt),
    .stat_fail_cnt  (stat_fail_cnt),
    .stat_retry_cnt (stat_retry_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one command (caller guarantees cmd_ready=1) and follows it until
  // cmd_ready returns. ack is raised during the ack_at-th cycle in which
  // req_valid is high (0 = never); ack_noise drives ack high whenever
  // req_valid is low.
  task automatic run_cmd(input logic [4:0] cid, input logic [31:0] amt,
                         input int ack_at, input bit ack_noise,
                         output int hi, output int win, output int dones,
                         output logic ok, output logic [4:0] dcid,
                         output int lat, output int id_bad);
    logic prev;
    bit   fin;
    hi = 0; win = 0; dones = 0; ok = 1'b0; dcid = '0; lat = 0; id_bad = 0;
    prev = 1'b0; fin = 1'b0;
    bus_if.cmd_valid     = 1'b1;
    bus_if.cmd_client_id = cid;
    bus_if.cmd_amount    = amt;
    step();
    bus_if.cmd_valid = 1'b0;
    for (int i = 1; i <= 200 && !fin; i++) begin
      if (bus_if.req_valid) begin
        hi++;
        if (!prev) win++;
        if (bus_if.client_id !== cid || bus_if.amount !== amt) id_bad++;
      end
      prev = bus_if.req_valid;
      if (bus_if.done_valid) begin
        dones++;
        ok   = bus_if.done_ok;
        dcid = bus_if.done_client_id;
        lat  = i;
      end
      bus_if.ack = bus_if.req_valid ? (hi == ack_at) : ack_noise;
      if (bus_if.cmd_ready) fin = 1'b1;
      else step();
    end
    bus_if.ack = 1'b0;
    chk("cmd_finished_in_budget", {31'd0, fin}, 32'd1);
  endtask

  task automatic expect_cmd(input string tag, input logic [4:0] cid, input logic [31:0] amt,
                            input int ack_at, input bit noise,
                            input int e_hi, input int e_win, input logic e_ok, input int e_lat);
    int hi, win, dones, lat, id_bad;
    logic ok;
    logic [4:0] dcid;
    run_cmd(cid, amt, ack_at, noise, hi, win, dones, ok, dcid, lat, id_bad);
    chk({tag, "/req_valid_cycles"}, hi, e_hi);
    chk({tag, "/req_windows"}, win, e_win);
    chk({tag, "/done_pulses"}, dones, 1);
    chk({tag, "/done_ok"}, {31'd0, ok}, {31'd0, e_ok});
    chk({tag, "/done_client_id"}, {27'd0, dcid}, {27'd0, cid});
    chk({tag, "/done_latency"}, lat, e_lat);
    chk({tag, "/req_fields_stable"}, id_bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid     = 1'b0;
    bus_if.cmd_client_id = '0;
    bus_if.cmd_amount    = '0;
    bus_if.ack           = 1'b0;
    step();
    step();
    chk("rst/cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
    chk("rst/req_valid", {31'd0, bus_if.req_valid}, 32'd0);
    chk("rst/client_id", {27'd0, bus_if.client_id}, 32'd0);
    chk("rst/amount", bus_if.amount, 32'd0);
    chk("rst/done_valid", {31'd0, bus_if.done_valid}, 32'd0);
    chk("rst/done_ok", {31'd0, bus_if.done_ok}, 32'd0);
    chk("rst/done_client_id", {27'd0, bus_if.done_client_id}, 32'd0);
    rst = 1'b0;
    step();
    chk("rel/cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);

    //           tag             cid    amount  ack_at noise hi win ok lat
    expect_cmd("ack3",          5'h1B, 32'hC5,  3,     0,    3,  1, 1, 4);
    expect_cmd("noack",         5'h08, 32'hC5,  0,     0,    48, 3, 0, 51);
    expect_cmd("noack_noise",   5'h08, 32'hC5,  0,     1,    48, 3, 0, 51);
    expect_cmd("ack_2nd_try",   5'h03, 32'h1,   17,    0,    17, 2, 1, 19);
    expect_cmd("zero_amount",   5'h1F, 32'h0,   0,     1,    0,  0, 1, 1);

    // Reset on cycle 5 of REQ with an ack in the following cycle
    bus_if.cmd_valid     = 1'b1;
    bus_if.cmd_client_id = 5'h08;
    bus_if.cmd_amount    = 32'h20C5;
    step();
    bus_if.cmd_valid = 1'b0;
    for (int i = 1; i < 5; i++) step();
    chk("midrst/req_valid_before", {31'd0, bus_if.req_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.ack = 1'b1;
    chk("midrst/req_valid_dropped", {31'd0, bus_if.req_valid}, 32'd0);
    chk("midrst/done_valid_0", {31'd0, bus_if.done_valid}, 32'd0);
    chk("midrst/cmd_ready_in_rst", {31'd0, bus_if.cmd_ready}, 32'd0);
    chk("midrst/client_id_cleared", {27'd0, bus_if.client_id}, 32'd0);
    step();
    bus_if.ack = 1'b0;
    chk("midrst/done_valid_1", {31'd0, bus_if.done_valid}, 32'd0);
    chk("midrst/cmd_ready_after", {31'd0, bus_if.cmd_ready}, 32'd1);
    chk("midrst/req_valid_ack_ignored", {31'd0, bus_if.req_valid}, 32'd0);
    step();
    chk("midrst/done_valid_2", {31'd0, bus_if.done_valid}, 32'd0);
    chk("midrst/req_valid_2", {31'd0, bus_if.req_valid}, 32'd0);
`ifdef CXL_REQ_STATS_EN
    chk("stats/ok_cleared", {16'd0, stat_ok_cnt}, 32'd0);
    chk("stats/fail_cleared", {16'd0, stat_fail_cnt}, 32'd0);
    chk("stats/retry_cleared", {16'd0, stat_retry_cnt}, 32'd0);
`endif

    expect_cmd("stats_ok",      5'h1B, 32'hC5,  3,     0,    3,  1, 1, 4);
    expect_cmd("stats_fail",    5'h08, 32'hC5,  0,     0,    48, 3, 0, 51);
`ifdef CXL_REQ_STATS_EN
    chk("stats/ok_1", {16'd0, stat_ok_cnt}, 32'd1);
    chk("stats/fail_1", {16'd0, stat_fail_cnt}, 32'd1);
    chk("stats/retry_2", {16'd0, stat_retry_cnt}, 32'd2);
`endif

    expect_cmd("ack_on_expiry", 5'h12, 32'h7,   16,    0,    16, 1, 1, 17);
`ifdef CXL_REQ_STATS_EN
    chk("stats/ok_2", {16'd0, stat_ok_cnt}, 32'd2);
    chk("stats/retry_no_inc_on_ack_expiry", {16'd0, stat_retry_cnt}, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cxl_get_requester.md
CXL_GET_REQUESTER -- requirements
Module: cxl_get_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles req_valid is held per attempt before it is abandoned (legal range 2..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3: total attempts per command before failure (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: an upstream get command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-007 SHALL have port cmd_client_id, input, 5 bits: requesting client.
REQ-008 SHALL have port cmd_amount, input, 32 bits: the amount requested.
REQ-009 SHALL have port req_valid, output, 1 bit: a request is presented to the get_Cxl responder.
REQ-010 SHALL have port client_id, output, 5 bits: the client of the request.
REQ-011 SHALL have port amount, output, 32 bits: the amount of the request.
REQ-012 SHALL have port ack, input, 1 bit: the responder's acknowledge.
REQ-013 SHALL have port done_valid, output, 1 bit: a one-cycle completion pulse.
REQ-014 SHALL have port done_ok, output, 1 bit: 1 = acknowledged, 0 = retries exhausted; valid only with done_valid.
REQ-015 SHALL have port done_client_id, output, 5 bits: the client of the completed command.

Function
REQ-016 SHALL implement states IDLE, REQ, BACKOFF and DONE.
REQ-017 IDLE: cmd_ready=1; when cmd_valid=1, the block SHALL latch the client ID and amount, clear the retry and timeout counters, and go to REQ.
REQ-018 REQ: req_valid=1, client_id and amount driven from the latched values and held stable; the timeout counter SHALL increment each cycle.
REQ-019 An ack sampled in REQ SHALL go to DONE with done_ok=1.
REQ-020 A command accepted at cycle N SHALL raise req_valid at N+1; an ack at cycle M SHALL give done_valid at M+1 and cmd_ready at M+2.
REQ-021 In REQ, when the timeout counter equals TIMEOUT_CYCLES-1 and ack=0, the block SHALL increment the retry count; it SHALL go to DONE with done_ok=0 if the retry count reaches MAX_RETRY, otherwise to BACKOFF.
REQ-022 BACKOFF SHALL last exactly 1 cycle with req_valid=0, then SHALL return to REQ with the timeout counter cleared.
REQ-023 An ack in the same cycle as the timeout expiry SHALL win: success, with no retry counted.
REQ-024 An ack while req_valid=0 (IDLE, BACKOFF or DONE) SHALL be ignored.
REQ-025 A command with cmd_amount=0 SHALL go IDLE->DONE directly with done_ok=1 and SHALL never assert req_valid.
REQ-026 DONE SHALL last 1 cycle: done_valid=1, done_client_id=latched ID, cmd_ready=0; then the block SHALL go to IDLE.
REQ-027 cmd_ready SHALL be 0 in every state except IDLE; the block SHALL hold at most one command in flight.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE and clear both counters, regardless of state.
REQ-029 Reset values SHALL be: cmd_ready=0 while rst is high and 1 after release; req_valid=0; client_id=0; amount=0; done_valid=0; done_ok=0; done_client_id=0.
REQ-030 A reset mid-request SHALL drop req_valid in the cycle after the reset edge, SHALL discard the command with no done pulse, and SHALL ignore an ack arriving in that cycle.

Configuration
REQ-031 With macro CXL_REQ_STATS_EN defined, the block SHALL add outputs stat_ok_cnt[15:0], stat_fail_cnt[15:0] and stat_retry_cnt[15:0].
REQ-032 With CXL_REQ_STATS_EN, these counters SHALL increment on each successful done, failed done and BACKOFF entry respectively, SHALL saturate at 0xFFFF and SHALL be cleared by rst.
REQ-033 Without CXL_REQ_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Shared package cxl_pkg SHALL hold client_id_t (5 bits), amount_t (32 bits) and the requester state enum, reused by get_Cxl.
REQ-035 The timeout/retry counting SHALL be implemented in one sub-module, cxl_req_timer, with inputs clear and enable and outputs expired and retries_exhausted.

Verification
REQ-036 Scenario: cmd client 0x1B, amount 0xC5, ack 3 cycles after req_valid rises -> one done pulse, done_ok=1, done_client_id=0x1B, req_valid high for 3 cycles.
REQ-037 Scenario: cmd client 0x08, amount 0xC5, ack never asserted, defaults -> 3 req_valid windows of 16 cycles with 1-cycle gaps, then done_ok=0.
REQ-038 Scenario: ack asserted exactly on cycle 16 of the first attempt -> done_ok=1 and stat_retry_cnt=0.
REQ-039 Scenario: cmd amount 0x0 -> done_valid 1 cycle after acceptance, done_ok=1, req_valid never high.
REQ-040 Scenario: rst asserted on cycle 5 of REQ for client 0x08, amount 0x20C5, with ack in the following cycle -> no done pulse and cmd_ready=1 after rst falls.
REQ-041 Scenario: with CXL_REQ_STATS_EN, one success then one failure -> stat_ok_cnt=1, stat_fail_cnt=1, stat_retry_cnt=2.
